// File: rtl/ctrl_pkg.sv
// Shared controller definitions: opcode map, next-PC select codes, fetch FSM states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package ctrl_pkg;

  // Major opcodes, ir[15:12].
  localparam logic [3:0] OP_LW    = 4'b0000;
  localparam logic [3:0] OP_SW    = 4'b0001;
  localparam logic [3:0] OP_JMP   = 4'b0010;
  localparam logic [3:0] OP_BRZ   = 4'b0100;
  localparam logic [3:0] OP_RTYPE = 4'b1000;
  localparam logic [3:0] OP_ADDI  = 4'b1100;
  localparam logic [3:0] OP_SUBI  = 4'b1101;
  localparam logic [3:0] OP_ANDI  = 4'b1110;
  localparam logic [3:0] OP_ORI   = 4'b1111;

  // Next-PC select driven by the controller. PC_ILL is the unused code,
  // treated as sequential but flagged.
  typedef enum logic [1:0] {
    PC_SEQ = 2'd0,
    PC_BR  = 2'd1,
    PC_JMP = 2'd2,
    PC_ILL = 2'd3
  } pcsel_e;

  // Fetch FSM: FETCH waits for the instruction word, ISSUE holds it until retire.
  typedef enum logic [0:0] {
    FETCH = 1'b0,
    ISSUE = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/npc_calc.sv
// Next-PC calculator: sequential, PC-relative branch, absolute jump, illegal select.
// Latency: purely combinational.
// Backpressure: none; the caller decides when npc is committed.
// Ports: pc (current PC), ir (low 12 bits of the held instruction),
//        pcsel (select code), npc (next PC, modulo 2^PC_W), err (illegal select).
module npc_calc
  import ctrl_pkg::*;
#(
  parameter int PC_W = 12
) (
  input  logic [PC_W-1:0] pc,
  input  logic [11:0]     ir,
  input  logic [1:0]      pcsel,
  output logic [PC_W-1:0] npc,
  output logic            err
);

  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] br_off;

  always_comb begin
    pc_inc = pc + PC_W'(1);
    // Branch offset is ir[7:0] as a signed byte, sign-extended to the PC width.
    br_off = PC_W'($signed(ir[7:0]));
    npc    = pc_inc;
    err    = 1'b0;
    case (pcsel)
      PC_SEQ:  npc = pc_inc;
      PC_BR:   npc = pc_inc + br_off;
      PC_JMP:  npc = PC_W'(ir);
      default: begin
        npc = pc_inc;
        err = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: reads one word from imem, holds it for the controller, then advances the PC.
// Latency: ack edge -> instr_valid one cycle; retire edge -> next imem_req one cycle (2 cycles/instr min).
// Backpressure: stall holds the issued instruction, PC and state; imem wait states hold FETCH.
// Ports: clk/rst_n; imem_req/imem_addr/imem_ack/imem_rdata memory read port;
//        stall/pcsel from the controller; opcode/func/imm/instr_valid/pc to the
//        controller and datapath; pcsel_err sticky illegal-select flag.
module fetch_unit
  import ctrl_pkg::*;
#(
  parameter int              PC_W     = 12,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [15:0]     imem_rdata,
  input  logic            stall,
  input  logic [1:0]      pcsel,
  output logic [3:0]      opcode,
  output logic [7:0]      func,
  output logic [11:0]     imm,
  output logic            instr_valid,
  output logic [PC_W-1:0] pc,
  output logic            pcsel_err
);

  fetch_state_e    state;
  logic [15:0]     ir;
  logic [PC_W-1:0] npc;
  logic            npc_err;

  npc_calc #(
    .PC_W (PC_W)
  ) u_npc_calc (
    .pc    (pc),
    .ir    (ir[11:0]),
    .pcsel (pcsel),
    .npc   (npc),
    .err   (npc_err)
  );

  // ir only loads in FETCH, so acks arriving in ISSUE are dropped and the
  // decode fields stay stable for the whole issue period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      ir        <= 16'h0000;
      pcsel_err <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (imem_ack) begin
            ir    <= imem_rdata;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (!stall) begin
            pc    <= npc;
            state <= FETCH;
            if (npc_err) begin
              pcsel_err <= 1'b1;
            end
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  assign imem_req    = (state == FETCH);
  assign imem_addr   = pc;
  assign instr_valid = (state == ISSUE);
  assign opcode      = ir[15:12];
  assign func        = ir[7:0];
  assign imm         = ir[11:0];

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam int PC_W = 12;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack = 1'b0;
  logic [15:0]     imem_rdata = 16'h0;
  logic            stall = 1'b0;
  logic [1:0]      pcsel = 2'd0;
  logic [3:0]      opcode;
  logic [7:0]      func;
  logic [11:0]     imm;
  logic            instr_valid;
  logic [PC_W-1:0] pc;
  logic            pcsel_err;

  int passed = 0;
  int total  = 0;

  // Scoreboard: expected fetch addresses and the words handed to the DUT.
  logic [PC_W-1:0] exp_addr_q[$];
  logic [15:0]     exp_ir_q[$];

  fetch_unit #(
    .PC_W     (PC_W),
    .RESET_PC (12'h000)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .pcsel       (pcsel),
    .opcode      (opcode),
    .func        (func),
    .imm         (imm),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pcsel_err   (pcsel_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  // Memory side: wait (bounded) for a request, hold ack off for wait_cycles
  // while recording whether the address stayed put, then return one word.
  task automatic do_fetch(input logic [15:0] word, input int wait_cycles,
                          output logic [PC_W-1:0] addr_seen, output logic held);
    int n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (imem_req !== 1'b1) begin
      addr_seen = 'x;
      held      = 1'b0;
      return;
    end
    addr_seen = imem_addr;
    held      = 1'b1;
    for (int i = 0; i < wait_cycles; i++) begin
      @(negedge clk);
      if (imem_addr !== addr_seen || imem_req !== 1'b1) held = 1'b0;
    end
    imem_ack   = 1'b1;
    imem_rdata = word;
    exp_ir_q.push_back(word);
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = 16'h0;
  endtask

  task automatic do_retire(input logic [1:0] sel);
    stall = 1'b0;
    pcsel = sel;
    @(negedge clk);
    pcsel = 2'd0;
  endtask

  // Steer the DUT to a known PC with a JMP instruction.
  task automatic jump_to(input logic [11:0] target);
    logic [PC_W-1:0] a;
    logic            h;
    do_fetch({4'h2, target}, 0, a, h);
    void'(exp_ir_q.pop_front());
    do_retire(2'd2);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    total++; if (imem_req !== 1'b1) $display("FAIL reset_req: got %b want 1", imem_req); else passed++;
    total++; if (imem_addr !== 12'h000) $display("FAIL reset_addr: got %h want 000", imem_addr); else passed++;
    total++; if (instr_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", instr_valid); else passed++;
    total++; if ({opcode, func, imm} !== 24'h0) $display("FAIL reset_fields: got %h want 000000", {opcode, func, imm}); else passed++;
    total++; if (pcsel_err !== 1'b0) $display("FAIL reset_err: got %b want 0", pcsel_err); else passed++;
  endtask

  task automatic test_seq();
    logic [PC_W-1:0] a, e;
    logic            h;
    logic [15:0]     w;
    for (int k = 0; k < 3; k++) exp_addr_q.push_back(PC_W'(k));
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      do_fetch(16'h8050 + 16'(k), 0, a, h);
      e = exp_addr_q.pop_front();
      total++; if (a !== e) $display("FAIL seq_addr%0d: got %h want %h", k, a, e); else passed++;
      total++; if (instr_valid !== 1'b1) $display("FAIL seq_valid%0d: got %b want 1", k, instr_valid); else passed++;
      w = exp_ir_q.pop_front();
      total++; if ({opcode, imm} !== w || func !== w[7:0]) $display("FAIL seq_ir%0d: got %h want %h", k, {opcode, imm}, w); else passed++;
      do_retire(2'd0);
      total++; if (instr_valid !== 1'b0 || imem_req !== 1'b1) $display("FAIL seq_gap%0d: got valid=%b req=%b want 0/1", k, instr_valid, imem_req); else passed++;
    end
  endtask

  task automatic test_branch();
    logic [PC_W-1:0] a, e;
    logic            h;
    logic [15:0]     w;
    jump_to(12'h010);
    exp_addr_q.push_back(12'h010);
    do_fetch(16'h40FC, 0, a, h);
    e = exp_addr_q.pop_front();
    total++; if (a !== e) $display("FAIL br_at: got %h want %h", a, e); else passed++;
    w = exp_ir_q.pop_front();
    total++; if ({opcode, imm} !== w) $display("FAIL br_ir: got %h want %h", {opcode, imm}, w); else passed++;
    do_retire(2'd1);
    exp_addr_q.push_back(12'h00D);
    do_fetch(16'h8000, 0, a, h);
    void'(exp_ir_q.pop_front());
    e = exp_addr_q.pop_front();
    total++; if (a !== e) $display("FAIL br_target: got %h want %h", a, e); else passed++;
    do_retire(2'd0);
  endtask

  task automatic test_jump();
    logic [PC_W-1:0] a, e;
    logic            h;
    do_fetch(16'h23A5, 0, a, h);
    void'(exp_ir_q.pop_front());
    do_retire(2'd2);
    exp_addr_q.push_back(12'h3A5);
    do_fetch(16'h8000, 0, a, h);
    void'(exp_ir_q.pop_front());
    e = exp_addr_q.pop_front();
    total++; if (a !== e) $display("FAIL jmp_target: got %h want %h", a, e); else passed++;
    do_retire(2'd0);
  endtask

  task automatic test_wrap();
    logic [PC_W-1:0] a, e;
    logic            h;
    jump_to(12'hFFF);
    exp_addr_q.push_back(12'hFFF);
    exp_addr_q.push_back(12'h000);
    do_fetch(16'hC001, 0, a, h);
    void'(exp_ir_q.pop_front());
    e = exp_addr_q.pop_front();
    total++; if (a !== e) $display("FAIL wrap_top: got %h want %h", a, e); else passed++;
    do_retire(2'd0);
    do_fetch(16'hC002, 0, a, h);
    void'(exp_ir_q.pop_front());
    e = exp_addr_q.pop_front();
    total++; if (a !== e) $display("FAIL wrap_zero: got %h want %h", a, e); else passed++;
    do_retire(2'd0);
  endtask

  task automatic test_stall();
    logic [PC_W-1:0] a, e;
    logic            h;
    logic [15:0]     w;
    jump_to(12'h100);
    do_fetch(16'hC123, 0, a, h);
    w = exp_ir_q.pop_front();
    // pcsel=JMP while stalled must not be taken.
    stall = 1'b1;
    pcsel = 2'd2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (pc !== 12'h100 || opcode !== w[15:12] || imem_req !== 1'b0 || instr_valid !== 1'b1)
        $display("FAIL stall_hold%0d: got pc=%h op=%h req=%b vld=%b want 100/%h/0/1", i, pc, opcode, imem_req, instr_valid, w[15:12]);
      else passed++;
    end
    do_retire(2'd0);
    total++; if (pc !== 12'h101 || imem_req !== 1'b1) $display("FAIL stall_retire: got pc=%h req=%b want 101/1", pc, imem_req); else passed++;
    exp_addr_q.push_back(12'h101);
    do_fetch(16'h8000, 0, a, h);
    void'(exp_ir_q.pop_front());
    e = exp_addr_q.pop_front();
    total++; if (a !== e) $display("FAIL stall_next: got %h want %h", a, e); else passed++;
    do_retire(2'd0);
  endtask

  task automatic test_delayed_ack();
    logic [PC_W-1:0] a, e;
    logic            h;
    logic [15:0]     w;
    jump_to(12'h200);
    exp_addr_q.push_back(12'h200);
    do_fetch(16'h1234, 4, a, h);
    w = exp_ir_q.pop_front();
    e = exp_addr_q.pop_front();
    total++; if (a !== e || h !== 1'b1) $display("FAIL dly_addr: got %h held=%b want %h held=1", a, h, e); else passed++;
    total++; if (instr_valid !== 1'b1) $display("FAIL dly_valid: got %b want 1", instr_valid); else passed++;
    stall      = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 16'hFFFF;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = 16'h0;
    total++; if ({opcode, imm} !== w) $display("FAIL spurious_ack: got %h want %h", {opcode, imm}, w); else passed++;
    do_retire(2'd0);
    exp_addr_q.push_back(12'h201);
    do_fetch(16'h8000, 0, a, h);
    void'(exp_ir_q.pop_front());
    e = exp_addr_q.pop_front();
    total++; if (a !== e) $display("FAIL dly_next: got %h want %h", a, e); else passed++;
    do_retire(2'd0);
  endtask

  task automatic test_pcsel_err();
    logic [PC_W-1:0] a, e;
    logic            h;
    jump_to(12'h300);
    do_fetch(16'hF000, 0, a, h);
    void'(exp_ir_q.pop_front());
    total++; if (pcsel_err !== 1'b0) $display("FAIL err_before: got %b want 0", pcsel_err); else passed++;
    do_retire(2'd3);
    total++; if (pcsel_err !== 1'b1) $display("FAIL err_set: got %b want 1", pcsel_err); else passed++;
    exp_addr_q.push_back(12'h301);
    do_fetch(16'h8000, 0, a, h);
    void'(exp_ir_q.pop_front());
    e = exp_addr_q.pop_front();
    total++; if (a !== e) $display("FAIL err_next: got %h want %h", a, e); else passed++;
    do_retire(2'd0);
    total++; if (pcsel_err !== 1'b1) $display("FAIL err_sticky: got %b want 1", pcsel_err); else passed++;
  endtask

  task automatic test_reset_mid_issue();
    logic [PC_W-1:0] a, e;
    logic            h;
    do_fetch(16'h2ABC, 0, a, h);
    void'(exp_ir_q.pop_front());
    pcsel = 2'd2;
    stall = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (pc !== 12'h000 || imem_req !== 1'b1 || instr_valid !== 1'b0 || opcode !== 4'h0 || pcsel_err !== 1'b0)
      $display("FAIL rst_async: got pc=%h req=%b vld=%b op=%h err=%b want 000/1/0/0/0", pc, imem_req, instr_valid, opcode, pcsel_err);
    else passed++;
    @(negedge clk);
    total++; if (pc !== 12'h000) $display("FAIL rst_hold: got %h want 000", pc); else passed++;
    pcsel = 2'd0;
    rst_n = 1'b1;
    exp_addr_q.push_back(12'h000);
    do_fetch(16'h8000, 0, a, h);
    void'(exp_ir_q.pop_front());
    e = exp_addr_q.pop_front();
    total++; if (a !== e) $display("FAIL rst_refetch: got %h want %h", a, e); else passed++;
    do_retire(2'd0);
  endtask

  initial begin
    test_reset();
    test_seq();
    test_branch();
    test_jump();
    test_wrap();
    test_stall();
    test_delayed_ack();
    test_pcsel_err();
    test_reset_mid_issue();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter PC_W, default 12, PC and instruction-memory word-address width.
REQ-002 SHALL have parameter RESET_PC, default 0, first fetch address after reset.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port imem_req  output  1  instruction-memory read request.
REQ-006 SHALL have port imem_addr  output  PC_W  word address of the request (equals pc).
REQ-007 SHALL have port imem_ack  input  1  read data valid this cycle.
REQ-008 SHALL have port imem_rdata  input  16  instruction word.
REQ-009 SHALL have port stall  input  1  datapath not ready to retire the issued instruction.
REQ-010 SHALL have port pcsel  input  2  next-PC select from the controller (0 sequential, 1 branch, 2 jump, 3 illegal).
REQ-011 SHALL have port opcode  output  4  ir[15:12] to the controller.
REQ-012 SHALL have port func  output  8  ir[7:0] to the controller.
REQ-013 SHALL have port imm  output  12  ir[11:0] to the datapath.
REQ-014 SHALL have port instr_valid  output  1  high in every ISSUE cycle; the instruction retires in an ISSUE cycle with stall low.
REQ-015 SHALL have port pc  output  PC_W  address of the held instruction.
REQ-016 SHALL have port pcsel_err  output  1  sticky flag, set when pcsel==3 is sampled at retire.

Function
REQ-017 SHALL implement a two-state FSM: FETCH, ISSUE.
REQ-018 In FETCH, SHALL drive imem_req=1 and imem_addr=pc; instr_valid=0.
REQ-019 In FETCH with imem_ack=1, SHALL load ir<=imem_rdata and go to ISSUE. A zero-wait ack in the first FETCH cycle is legal.
REQ-020 In ISSUE, SHALL drive imem_req=0 and instr_valid=1; opcode, func and imm SHALL be stable for the whole ISSUE period.
REQ-021 In ISSUE with stall=1, SHALL hold state, pc and ir unchanged.
REQ-022 In ISSUE with stall=0, SHALL update pc per pcsel and return to FETCH.
REQ-023 pcsel=0: pc<=pc+1. pcsel=1: pc<=pc+1+sext(ir[7:0]). pcsel=2: pc<=ir[11:0] (zero-extended or truncated to PC_W). pcsel=3: pc<=pc+1 and pcsel_err<=1.
REQ-024 All PC arithmetic SHALL be modulo 2^PC_W. Example: 0xFFF+1 wraps to 0x000.
REQ-025 Latency SHALL be as follows: imem_ack edge to instr_valid=1 is 1 cycle; retire edge to the next imem_req=1 is 1 cycle. Minimum throughput is one instruction per 2 cycles.
REQ-026 imem_ack in ISSUE SHALL be ignored; ir SHALL NOT change.
REQ-027 pcsel and stall SHALL be sampled only in ISSUE; they are don't-care in FETCH.
REQ-028 An unbounded imem_ack wait SHALL hold FETCH with imem_addr stable.

Reset
REQ-029 On rst_n=0, SHALL asynchronously force state=FETCH, pc=RESET_PC, ir=16'h0000, pcsel_err=0.
REQ-030 During reset, outputs SHALL be: imem_req=1, imem_addr=RESET_PC, instr_valid=0, opcode/func/imm=0.
REQ-031 Reset asserted mid-fetch or mid-issue SHALL abandon the instruction; no retire or PC update SHALL occur.
REQ-032 The first clock edge after rst_n rises SHALL accept imem_ack for address RESET_PC.

Structure
REQ-033 The shared package ctrl_pkg SHALL hold the opcode constants (LW=0000, SW=0001, JMP=0010, BRZ=0100, RTYPE=1000, ADDI=1100, SUBI=1101, ANDI=1110, ORI=1111).
REQ-034 ctrl_pkg SHALL hold the pcsel enum (PC_SEQ=0, PC_BR=1, PC_JMP=2) and the fetch-state enum.
REQ-035 Next-PC computation SHALL be a combinational sub-module npc_calc (pc, ir, pcsel -> npc, err). The FSM and registers SHALL stay in fetch_unit.

Verification
REQ-036 Reset release, ack 0 cycles, pcsel=0 -> imem_addr sequence 0,1,2; instr_valid pulses every 2nd cycle.
REQ-037 ir=16'h4_0FC at pc=0x010, pcsel=1 -> next imem_addr=0x00D (0x011-4). At pc=0xFFF, pcsel=0 -> next imem_addr=0x000.
REQ-038 ir=16'h2_3A5, pcsel=2 -> next imem_addr=0x3A5.
REQ-039 stall=1 for 3 ISSUE cycles -> pc and opcode are unchanged and imem_req=0 throughout; stall=0 -> retire once.
REQ-040 ack delayed 4 cycles and a spurious ack in ISSUE -> imem_addr is held for 4 cycles and ir is unchanged by the spurious ack.
REQ-041 rst_n low mid-ISSUE with pcsel=2 -> pc=RESET_PC immediately and no jump is taken. pcsel=3 at retire -> pcsel_err=1 until reset.
